vecmul_scheduler: RTL and testbench
===================================

# vecmul_scheduler

Round-robin scheduler that shares one `vector_multiplier` engine among `NUM_REQ` requesters. It accepts one job at a time over per-requester valid/ready ports, latches the operands, pulses the engine's `start`, and waits for `done`. It then returns the element-wise product on a single tagged response channel. It sits between the AI-workload clients (matrix tile walkers) and the multiplier datapath.

## Interface
- `NUM_REQ`, 4: number of requesters (2..16).
- `VECTOR_SIZE`, 8: elements per vector; must match the engine.
- `DATA_WIDTH`, 16: bits per element; must match the engine.
- `TIMEOUT_CYCLES`, 16: WAIT-state watchdog limit; only used with `VMS_TIMEOUT_EN`.
- `ID_W`: localparam, `$clog2(NUM_REQ)`.
- `V`: localparam, `DATA_WIDTH*VECTOR_SIZE`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester job request.
- `req_ready`  out  NUM_REQ  one-hot grant; a job transfers when `req_valid[i] & req_ready[i]`.
- `req_a`  in  NUM_REQ*V  flattened operand A; requester i occupies slice `[V*(i+1)-1 : V*i]`.
- `req_b`  in  NUM_REQ*V  flattened operand B, same slicing as `req_a`.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_id`  out  ID_W  index of the requester that owns the response.
- `resp_data`  out  V  element-wise product.
- `resp_err`  out  1  watchdog abort flag.
- `busy`  out  1  high in any state other than IDLE.
- `mul_start`  out  1  one-cycle start pulse to the engine.
- `mul_vector_a`  out  V  operand A to the engine.
- `mul_vector_b`  out  V  operand B to the engine.
- `mul_result`  in  V  engine result.
- `mul_done`  in  1  engine completion pulse.

## Operation
FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Grant is combinational: search `req_valid` starting at `rr_ptr`, wrapping modulo NUM_REQ.
  - The first hit gets `req_ready`; all other bits stay 0. No requests means no grant.
  - On transfer: latch that requester's A, B and id into operand registers, then go to ISSUE.
- **ISSUE:** `mul_start`=1 for exactly this cycle, then go to WAIT.
- **WAIT:**
  - On `mul_done`: latch `mul_result` into `resp_data`, set `resp_err`=0, go to RESP.
  - Otherwise stay in WAIT.
- **RESP:**
  - `resp_valid`=1. `resp_id`, `resp_data` and `resp_err` hold stable until `resp_ready`.
  - On `resp_valid & resp_ready`: set `rr_ptr <= (resp_id+1) mod NUM_REQ`, go to IDLE.
- `mul_vector_a` and `mul_vector_b` are driven continuously from the operand registers and stay stable through ISSUE and WAIT.
- `req_ready` is 0 in every state except IDLE, so there is only one job in flight.
- `mul_done` outside WAIT is ignored.
- Arithmetic belongs to the engine: each lane is the low DATA_WIDTH bits of an unsigned product. The scheduler passes `resp_data` through unmodified.
- **Reset (any time, including mid-WAIT):**
  - State goes to IDLE and `rr_ptr` to 0.
  - Operand and response registers go to 0. Any pending job is discarded.
  - Output reset values: `req_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_data`=0, `resp_err`=0, `busy`=0, `mul_start`=0, `mul_vector_a`/`mul_vector_b`=0.

## Timing
- Transfer in cycle 0 (IDLE). ISSUE is cycle 1, with `mul_start` high.
- With the team engine, `mul_done` is high in cycle 3 and `resp_valid` rises in cycle 4. Accept-to-response latency is therefore 4 cycles.
- If `resp_ready` is high in cycle 4, the FSM is in IDLE in cycle 5 and the next transfer can happen there. Peak throughput is one job per 5 cycles.
- `mul_start` is a registered, state-decoded output: it is never high for 2 consecutive cycles and never high outside ISSUE.
- Simultaneous requests are served strictly in round-robin order. A requester that holds `req_valid` waits at most NUM_REQ-1 jobs.
- A requester that drops `req_valid` before grant is legal; no transfer occurs.

## Configuration
- Macro `VMS_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without `mul_done`, go to RESP with `resp_data`=0 and `resp_err`=1.
  - A late `mul_done` is ignored.
- **Undefined:**
  - No counter is built; WAIT lasts indefinitely.
  - `resp_err` is tied to 0.

## Test plan
- **Single job:** requester 2, all A lanes 3, all B lanes 5. Expect `req_ready`=4'b0100 in cycle 0 and `mul_start` pulse in cycle 1. In cycle 4 expect `resp_valid`=1, `resp_id`=2, every lane 16'h000F, `resp_err`=0.
- **Round-robin:** all four `req_valid` held high, `resp_ready`=1. Expect grant order 0,1,2,3,0, one grant every 5 cycles.
- **Overflow passthrough:** lane 0 A=16'h0100, B=16'h0100; lane 1 A=16'hFFFF, B=16'h0002. Expect lane 0 = 16'h0000 and lane 1 = 16'hFFFE.
- **Backpressure:** `resp_ready` low for 10 cycles after `resp_valid`. Expect outputs held stable, `req_ready`=0 throughout, and acceptance on the cycle `resp_ready` rises.
- **Reset mid-WAIT:** assert `rst_n`=0 in cycle 2 and release. Expect every output at its reset value, no response ever issued, and the next job served normally from requester 0's priority.
- **Timeout** (`VMS_TIMEOUT_EN`, engine stubbed to never assert `mul_done`, TIMEOUT_CYCLES=16): expect `resp_valid` with `resp_err`=1 and `resp_data`=0 after 16 WAIT cycles. Without the macro, expect `busy` to remain 1.

Source files
------------

// File: rtl/vecmul_scheduler.sv
// vecmul_scheduler: round-robin front end sharing one vector_multiplier engine.
// Define VMS_TIMEOUT_EN to build the WAIT-state watchdog that drives resp_err.
module vecmul_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int VECTOR_SIZE    = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int ID_W          = $clog2(NUM_REQ),
    localparam int V             = DATA_WIDTH * VECTOR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*V-1:0] req_a,
    input  logic [NUM_REQ*V-1:0] req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [V-1:0]         resp_data,
    output logic                 resp_err,
    output logic                 busy,
    output logic                 mul_start,
    output logic [V-1:0]         mul_vector_a,
    output logic [V-1:0]         mul_vector_b,
    input  logic [V-1:0]         mul_result,
    input  logic                 mul_done
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_id;
    logic [V-1:0]       r_a;
    logic [V-1:0]       r_b;
    logic [V-1:0]       r_data;
    logic               r_start;
    logic               r_busy;
    logic               r_rvalid;

    logic               w_hit;
    logic [ID_W-1:0]    w_gid;
    logic [ID_W-1:0]    w_idx;
    logic [NUM_REQ-1:0] w_grant;

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("vecmul_scheduler: unsupported parameter set");
    end

    // First requesting index at or after the pointer, wrapping.
    always_comb begin
        w_hit = 1'b0;
        w_gid = '0;
        w_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_hit && req_valid[w_idx]) begin
                w_hit = 1'b1;
                w_gid = w_idx;
            end
        end
        w_grant = w_hit ? (NUM_REQ'(1) << w_gid) : '0;
    end

    assign req_ready = (rst_n && r_state == S_IDLE) ? w_grant : '0;

`ifdef VMS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tcnt;
    logic          r_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_data   <= '0;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
            r_rvalid <= 1'b0;
`ifdef VMS_TIMEOUT_EN
            r_tcnt   <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_id    <= w_gid;
                        r_a     <= req_a[int'(w_gid)*V +: V];
                        r_b     <= req_b[int'(w_gid)*V +: V];
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef VMS_TIMEOUT_EN
                    r_tcnt  <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        r_data   <= mul_result;
                        r_rvalid <= 1'b1;
                        r_state  <= S_RESP;
`ifdef VMS_TIMEOUT_EN
                        r_err    <= 1'b0;
                    end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_data   <= '0;
                        r_err    <= 1'b1;
                        r_rvalid <= 1'b1;
                        r_state  <= S_RESP;
`endif
                    end
`ifdef VMS_TIMEOUT_EN
                    r_tcnt <= r_tcnt + 1'b1;
`endif
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_rr_ptr <= ID_W'((int'(r_id) + 1) % NUM_REQ);
                        r_rvalid <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign resp_valid   = r_rvalid;
    assign resp_id      = r_id;
    assign resp_data    = r_data;
    assign busy         = r_busy;
    assign mul_start    = r_start;
    assign mul_vector_a = r_a;
    assign mul_vector_b = r_b;
`ifdef VMS_TIMEOUT_EN
    assign resp_err     = r_err;
`else
    assign resp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_vecmul_scheduler.sv
// tb_vecmul_scheduler: job-level reference model plus directed and random jobs.
// Engine stub answers 2..5 cycles after mul_start, or never when stalled.
module tb_vecmul_scheduler;
    localparam int N    = 4;
    localparam int VS   = 8;
    localparam int DW   = 16;
    localparam int TO   = 16;
    localparam int ID_W = 2;
    localparam int V    = DW * VS;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*V-1:0] req_a = '0;
    logic [N*V-1:0] req_b = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b0;
    logic [ID_W-1:0] resp_id;
    logic [V-1:0]   resp_data;
    logic           resp_err;
    logic           busy;
    logic           mul_start;
    logic [V-1:0]   mul_vector_a;
    logic [V-1:0]   mul_vector_b;
    logic [V-1:0]   mul_result = '0;
    logic           mul_done = 1'b0;

    vecmul_scheduler #(
        .NUM_REQ(N), .VECTOR_SIZE(VS), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
        .busy(busy), .mul_start(mul_start),
        .mul_vector_a(mul_vector_a), .mul_vector_b(mul_vector_b),
        .mul_result(mul_result), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Job-level model: is a job held, cycles since accept, result captured.
    bit              m_job, m_have, m_err;
    int              m_age, m_wcnt, m_ptr;
    logic [ID_W-1:0] m_id;
    logic [V-1:0]    m_a, m_b, m_data;

    int              eng_t = 0;
    logic [V-1:0]    eng_res = '0;
    bit              eng_stall = 0, eng_fixed = 1, spur_en = 0;

    logic [N-1:0]    s_rr;
    logic            s_start, s_rv, s_busy, s_err;
    logic [ID_W-1:0] s_id;
    logic [V-1:0]    s_data, s_va, s_vb;
    int              g_idx[$];
    int              g_cyc[$];

    function automatic int pick(logic [N-1:0] rv, int ptr);
        for (int k = 0; k < N; k++)
            if (rv[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(int i);
        logic [N-1:0] r;
        r = '0;
        if (i >= 0) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [V-1:0] lanes_mul(logic [V-1:0] a, logic [V-1:0] b);
        logic [V-1:0] r;
        logic [31:0]  p;
        for (int l = 0; l < VS; l++) begin
            p = {16'b0, a[l*DW +: DW]} * {16'b0, b[l*DW +: DW]};
            r[l*DW +: DW] = p[DW-1:0];
        end
        return r;
    endfunction

    function automatic bit m_waiting();
        return m_job && !m_have && m_age >= 2;
    endfunction

    task automatic chk(input string nm, input logic [V-1:0] act, input logic [V-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_job = 0; m_have = 0; m_err = 0;
        m_age = 0; m_wcnt = 0; m_ptr = 0;
        m_id = '0; m_a = '0; m_b = '0; m_data = '0;
    endtask

    task automatic compare();
        logic [N-1:0] exp_rr;
        exp_rr = (!rst_n || m_job) ? '0 : onehot(pick(req_valid, m_ptr));
        chk("req_ready", V'(req_ready), V'(exp_rr));
        chk("mul_start", V'(mul_start), V'(m_job && m_age == 1));
        chk("resp_valid", V'(resp_valid), V'(m_have));
        chk("busy", V'(busy), V'(m_job));
        chk("resp_id", V'(resp_id), V'(m_id));
        chk("resp_data", resp_data, m_data);
        chk("resp_err", V'(resp_err), V'(m_err));
        chk("mul_vector_a", mul_vector_a, m_a);
        chk("mul_vector_b", mul_vector_b, m_b);
    endtask

    task automatic model_update();
        int g;
        bit w;
        if (!rst_n) begin
            model_reset();
            return;
        end
        w = m_waiting();
        if (!m_job) begin
            g = pick(req_valid, m_ptr);
            if (g >= 0) begin
                m_job = 1; m_age = 1; m_wcnt = 0;
                m_id = ID_W'(g);
                m_a = req_a[g*V +: V];
                m_b = req_b[g*V +: V];
            end
        end else begin
            if (m_have) begin
                if (resp_ready) begin
                    m_job = 0; m_have = 0;
                    m_ptr = (int'(m_id) + 1) % N;
                end
            end else if (w) begin
                if (mul_done) begin
                    m_have = 1; m_data = mul_result; m_err = 0;
                end
`ifdef VMS_TIMEOUT_EN
                else if (m_wcnt == TO - 1) begin
                    m_have = 1; m_data = '0; m_err = 1;
                end
                m_wcnt++;
`endif
            end
            if (m_age < 2) m_age++;
        end
    endtask

    // One clock: engine drive, compare, model advance; returns at next negedge.
    task automatic step();
        if (eng_t == 1) begin
            mul_done = 1'b1;
            mul_result = eng_res;
            eng_t = 0;
        end else begin
            if (eng_t > 1) eng_t--;
            mul_done = spur_en && !m_waiting() && ($urandom_range(0, 7) == 0);
            mul_result = {$urandom, $urandom, $urandom, $urandom};
        end
        #1;
        if (!rst_n) model_reset();
        compare();
        s_rr = req_ready; s_start = mul_start; s_rv = resp_valid;
        s_busy = busy; s_err = resp_err; s_id = resp_id;
        s_data = resp_data; s_va = mul_vector_a; s_vb = mul_vector_b;
        if (s_rr != '0) begin
            g_idx.push_back($clog2(s_rr));
            g_cyc.push_back(cyc);
        end
        @(posedge clk);
        model_update();
        if (!rst_n) eng_t = 0;
        else if (s_start && !eng_stall) begin
            eng_t = eng_fixed ? 2 : $urandom_range(2, 5);
            eng_res = lanes_mul(s_va, s_vb);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic rand_ops();
        for (int w = 0; w < N*V/32; w++) begin
            req_a[w*32 +: 32] = $urandom;
            req_b[w*32 +: 32] = $urandom;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [V-1:0] ta, tb, exp_d;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        model_reset();
        @(negedge clk);

        // reset state
        step();
        step();
        chk("rst busy", V'(s_busy), '0);
        chk("rst resp_valid", V'(s_rv), '0);
        chk("rst mul_start", V'(s_start), '0);
        chk("rst resp_data", s_data, '0);
        rst_n = 1'b1;
        step();

        // single job from requester 2: 3*5 per lane
        req_a[2*V +: V] = {VS{16'd3}};
        req_b[2*V +: V] = {VS{16'd5}};
        req_valid = 4'b0100;
        step();
        chk("single grant c0", V'(s_rr), V'(4'b0100));
        req_valid = '0;
        step();
        chk("single start c1", V'(s_start), V'(1'b1));
        step();
        chk("single start c2", V'(s_start), '0);
        step();
        chk("single no resp c3", V'(s_rv), '0);
        resp_ready = 1'b1;
        step();
        chk("single resp_valid c4", V'(s_rv), V'(1'b1));
        chk("single resp_id c4", V'(s_id), V'(2'd2));
        chk("single data c4", s_data, {VS{16'h000F}});
        chk("single err c4", V'(s_err), '0);
        resp_ready = 1'b0;
        step();
        chk("single idle c5", V'(s_busy), '0);

        // round robin from a fresh pointer
        do_reset();
        rand_ops();
        req_valid = '1;
        resp_ready = 1'b1;
        g_idx.delete();
        g_cyc.delete();
        repeat (25) step();
        req_valid = '0;
        chk("rr grant count", V'(g_idx.size()), V'(5));
        for (int i = 0; i < 5 && i < g_idx.size(); i++)
            chk("rr order", V'(g_idx[i]), V'(exp_order[i]));
        for (int i = 1; i < 5 && i < g_cyc.size(); i++)
            chk("rr spacing", V'(g_cyc[i] - g_cyc[i-1]), V'(5));

        // lane overflow passes through truncated
        ta = {$urandom, $urandom, $urandom, $urandom};
        tb = {$urandom, $urandom, $urandom, $urandom};
        ta[15:0] = 16'h0100; tb[15:0] = 16'h0100;
        ta[31:16] = 16'hFFFF; tb[31:16] = 16'h0002;
        req_a[1*V +: V] = ta;
        req_b[1*V +: V] = tb;
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        repeat (3) step();
        chk("ovf valid", V'(s_rv), '0);
        step();
        exp_d = s_data;
        chk("ovf lane0", V'(exp_d[15:0]), V'(16'h0000));
        chk("ovf lane1", V'(exp_d[31:16]), V'(16'hFFFE));

        // backpressure with every requester waiting
        rand_ops();
        resp_ready = 1'b0;
        req_valid = '1;
        step();
        chk("bp grant", V'(s_rr), V'(4'b0100));
        repeat (3) step();
        exp_d = lanes_mul(req_a[2*V +: V], req_b[2*V +: V]);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp hold valid", V'(s_rv), V'(1'b1));
            chk("bp hold data", s_data, exp_d);
            chk("bp hold id", V'(s_id), V'(2'd2));
            chk("bp no ready", V'(s_rr), '0);
        end
        resp_ready = 1'b1;
        step();
        chk("bp accept valid", V'(s_rv), V'(1'b1));
        step();
        chk("bp next grant", V'(s_rr), V'(4'b1000));
        req_valid = '0;
        repeat (5) step();

        // reset while waiting on the engine
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        rst_n = 1'b0;
        step();
        chk("midrst busy", V'(s_busy), '0);
        chk("midrst va", s_va, '0);
        chk("midrst id", V'(s_id), '0);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("midrst no resp", V'(s_rv), '0);
        end
        req_valid = '1;
        step();
        chk("midrst prio0", V'(s_rr), V'(4'b0001));
        req_valid = '0;
        repeat (5) step();

        // engine never answers
        eng_stall = 1;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        for (int k = 1; k <= 25; k++) begin
            step();
`ifdef VMS_TIMEOUT_EN
            if (k == 18) begin
                chk("to valid", V'(s_rv), V'(1'b1));
                chk("to err", V'(s_err), V'(1'b1));
                chk("to data", s_data, '0);
            end
`else
            chk("stall busy", V'(s_busy), V'(1'b1));
            chk("stall no resp", V'(s_rv), '0);
`endif
        end
        eng_stall = 0;
        do_reset();

        // random traffic
        eng_fixed = 0;
        spur_en = 1;
        for (int k = 0; k < 3000; k++) begin
            rand_ops();
            req_valid = N'($urandom_range(0, 15) & $urandom_range(0, 15));
            resp_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 799) != 0);
            step();
            rst_n = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
